// File: rtl/pwd_lock_ctrl_if.sv
// pwd_lock_ctrl_if: key events from the keypad scanner and the lock's status outputs.
interface pwd_lock_ctrl_if #(
    parameter int DIGITS    = 4,
    parameter int MAX_TRIES = 3
);
    localparam int PW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int FW = $clog2(MAX_TRIES + 1);
    logic          key_valid;
    logic [3:0]    key_val;
    logic          unlock;
    logic          lockout;
    logic          pwd_update;
    logic [2:0]    state;
    logic [PW-1:0] entry_buf;
    logic [CW-1:0] entry_cnt;
    logic [FW-1:0] fail_cnt;
    modport master (
        output key_valid, key_val,
        input  unlock, lockout, pwd_update, state, entry_buf, entry_cnt, fail_cnt
    );
    modport slave (
        input  key_valid, key_val,
        output unlock, lockout, pwd_update, state, entry_buf, entry_cnt, fail_cnt
    );
endinterface

// File: rtl/pwd_lock_ctrl.sv
// pwd_lock_ctrl: keypad code lock with unlock window, in-session password change and timed lockout.
module pwd_lock_ctrl #(
    parameter int                DIGITS      = 4,
    parameter int                MAX_TRIES   = 3,
    parameter int                OPEN_CYCLES = 250_000_000,
    parameter int                LOCK_CYCLES = 500_000_000,
    parameter logic [4*DIGITS-1:0] INIT_PWD  = '0
) (
    input logic             clk,
    input logic             rst,
    pwd_lock_ctrl_if.slave  bus
);
    localparam int PW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam logic [CW-1:0] FULL      = CW'(DIGITS);
    localparam logic [FW-1:0] LAST_TRY  = FW'(MAX_TRIES - 1);
    localparam logic [31:0]   OPEN_LAST = 32'(OPEN_CYCLES - 1);
    localparam logic [31:0]   LOCK_LAST = 32'(LOCK_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ENTRY     = 3'd1,
        CHECK     = 3'd2,
        OPEN      = 3'd3,
        NEW_ENTRY = 3'd4,
        LOCKOUT   = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] buf_q, buf_d, pwd_q, pwd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] fail_q, fail_d;
    logic [31:0]   timer_q, timer_d;
    logic          unlock_q, lockout_q, upd_q, commit;
    logic          key_f, key_e, key_dig;

    assign key_f   = bus.key_valid && bus.key_val == 4'hF;
    assign key_e   = bus.key_valid && bus.key_val == 4'hE;
    assign key_dig = bus.key_valid && bus.key_val < 4'hE;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        pwd_d   = pwd_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: if (key_f) begin
                state_d = ENTRY;
                buf_d   = '0;
                cnt_d   = '0;
            end
            ENTRY, NEW_ENTRY: begin
                if (key_dig && cnt_q != FULL) begin
                    buf_d[4*int'(cnt_q) +: 4] = bus.key_val;
                    cnt_d = cnt_q + CW'(1);
                end else if (key_e && cnt_q != '0) begin
                    buf_d[4*(int'(cnt_q)-1) +: 4] = 4'h0;
                    cnt_d = cnt_q - CW'(1);
                end else if (key_e) begin
                    state_d = IDLE;
                end else if (key_f && state_q == ENTRY) begin
                    state_d = CHECK;
                end else if (key_f && cnt_q == FULL) begin
                    pwd_d   = buf_q;
                    commit  = 1'b1;
                    state_d = IDLE;
                    buf_d   = '0;
                    cnt_d   = '0;
                end
            end
            CHECK: begin
                buf_d = '0;
                cnt_d = '0;
                if (cnt_q == FULL && buf_q == pwd_q) begin
                    state_d = OPEN;
                    fail_d  = '0;
                end else if (fail_q != LAST_TRY) begin
                    state_d = ENTRY;
                    fail_d  = fail_q + FW'(1);
                end else begin
                    state_d = LOCKOUT;
                    fail_d  = '0;
                end
            end
            // a key on the expiry cycle wins over the timeout
            OPEN: state_d = key_f ? NEW_ENTRY : (key_e || timer_q == OPEN_LAST) ? IDLE : OPEN;
            LOCKOUT: state_d = (timer_q == LOCK_LAST) ? IDLE : LOCKOUT;
            default: state_d = IDLE;
        endcase
        timer_d = (state_d != state_q || !(state_q inside {OPEN, LOCKOUT})) ? '0 : timer_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            cnt_q     <= '0;
            fail_q    <= '0;
            pwd_q     <= INIT_PWD;
            timer_q   <= '0;
            unlock_q  <= 1'b0;
            lockout_q <= 1'b0;
            upd_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            fail_q    <= fail_d;
            pwd_q     <= pwd_d;
            timer_q   <= timer_d;
            unlock_q  <= state_d == OPEN;
            lockout_q <= state_d == LOCKOUT;
            upd_q     <= commit;
        end
    end

    assign bus.unlock     = unlock_q;
    assign bus.lockout    = lockout_q;
    assign bus.pwd_update = upd_q;
    assign bus.state      = state_q;
    assign bus.entry_buf  = buf_q;
    assign bus.entry_cnt  = cnt_q;
    assign bus.fail_cnt   = fail_q;
endmodule

// File: tb/tb_pwd_lock_ctrl.sv
// tb_pwd_lock_ctrl: directed and random key sequences checked against a queue-based model of the lock.
module tb_pwd_lock_ctrl;
    localparam int OPEN_C = 10;
    localparam int LOCK_C = 20;
    localparam logic [15:0] INIT = 16'h4321;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_asrt = 0;
    int n_fail = 0;

    pwd_lock_ctrl_if #(.DIGITS(4), .MAX_TRIES(3)) bus ();
    pwd_lock_ctrl #(
        .DIGITS(4), .MAX_TRIES(3), .OPEN_CYCLES(OPEN_C), .LOCK_CYCLES(LOCK_C), .INIT_PWD(INIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // model: 0 idle, 1 entry, 2 check, 3 open, 4 new entry, 5 lockout
    int          ms, cyc, fails;
    int          q[$];
    logic [15:0] mpwd;
    bit          mupd;

    function automatic logic [15:0] pack();
        logic [15:0] b = '0;
        foreach (q[i]) b[4*i +: 4] = 4'(q[i]);
        return b;
    endfunction

    task automatic model_reset();
        ms = 0; cyc = 0; fails = 0; mpwd = INIT; mupd = 0;
        q.delete();
    endtask

    task automatic model_step(input bit kv, input logic [3:0] k);
        int ns = ms;
        mupd = 0;
        case (ms)
            0: if (kv && k == 4'hF) ns = 1;
            1, 4: if (kv) begin
                if (k < 4'hE) begin
                    if (q.size() < 4) q.push_back(int'(k));
                end else if (k == 4'hE) begin
                    if (q.size() > 0) void'(q.pop_back()); else ns = 0;
                end else if (ms == 1) ns = 2;
                else if (q.size() == 4) begin
                    mpwd = pack(); mupd = 1; ns = 0;
                end
            end
            2: begin
                if (q.size() == 4 && pack() == mpwd) begin ns = 3; fails = 0; end
                else if (fails + 1 < 3) begin ns = 1; fails++; end
                else begin ns = 5; fails = 0; end
                q.delete();
            end
            3: if (kv && k == 4'hF) ns = 4;
               else if ((kv && k == 4'hE) || cyc == OPEN_C - 1) ns = 0;
            5: if (cyc == LOCK_C - 1) ns = 0;
            default: ;
        endcase
        if (ns == 0) q.delete();
        cyc = (ns != ms) ? 0 : cyc + 1;
        ms = ns;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("state", 64'(bus.state), 64'(ms));
        chk("unlock", 64'(bus.unlock), 64'(ms == 3));
        chk("lockout", 64'(bus.lockout), 64'(ms == 5));
        chk("pwd_update", 64'(bus.pwd_update), 64'(mupd));
        chk("entry_buf", 64'(bus.entry_buf), 64'(pack()));
        chk("entry_cnt", 64'(bus.entry_cnt), 64'(q.size()));
        chk("fail_cnt", 64'(bus.fail_cnt), 64'(fails));
    endtask

    task automatic step(input bit kv, input logic [3:0] k);
        bus.key_valid = kv;
        bus.key_val   = k;
        @(posedge clk);
        model_step(kv, k);
        #1;
        bus.key_valid = 1'b0;
        check_all();
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            byte c = s[i];
            step(1'b1, (c >= "A") ? 4'(c - "A" + 10) : 4'(c - "0"));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.key_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.key_valid = 1'b0;
        bus.key_val   = 4'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset_state", 64'(bus.state), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        send("F1234F");
        chk("check_state", 64'(bus.state), 64'd2);
        n = 0;
        repeat (14) begin step(1'b0, 4'h0); n += int'(bus.unlock); end
        chk("open_len", 64'(n), 64'(OPEN_C));
        chk("after_open", 64'(bus.state), 64'd0);

        send("F19E234F");
        chk("bs_buf", 64'(bus.entry_buf), 64'h4321);
        step(1'b0, 4'h0);
        chk("bs_open", 64'(bus.state), 64'd3);
        send("E");
        send("FE");
        chk("fe_idle", 64'(bus.state), 64'd0);
        chk("fe_cnt", 64'(bus.entry_cnt), 64'd0);

        send("F12345");
        chk("ovf_cnt", 64'(bus.entry_cnt), 64'd4);
        send("F");
        step(1'b0, 4'h0);
        chk("ovf_open", 64'(bus.state), 64'd3);
        send("E");
        send("F12F");
        step(1'b0, 4'h0);
        chk("short_fail", 64'(bus.fail_cnt), 64'd1);
        chk("short_entry", 64'(bus.state), 64'd1);

        send("0000F");
        step(1'b0, 4'h0);
        chk("fail2", 64'(bus.fail_cnt), 64'd2);
        send("0000F");
        step(1'b0, 4'h0);
        chk("lock_state", 64'(bus.state), 64'd5);
        n = int'(bus.lockout);
        repeat (25) begin step(1'b1, 4'($urandom_range(0, 14))); n += int'(bus.lockout); end
        chk("lock_len", 64'(n), 64'(LOCK_C));
        chk("lock_idle", 64'(bus.state), 64'd0);
        send("F1234F");
        step(1'b0, 4'h0);
        chk("post_lock_open", 64'(bus.state), 64'd3);

        send("F9876F");
        chk("upd_pulse", 64'(bus.pwd_update), 64'd1);
        step(1'b0, 4'h0);
        chk("upd_once", 64'(bus.pwd_update), 64'd0);
        send("F1234F");
        step(1'b0, 4'h0);
        chk("old_pwd_fails", 64'(bus.state), 64'd1);
        send("E");
        send("F9876F");
        step(1'b0, 4'h0);
        chk("new_pwd_opens", 64'(bus.state), 64'd3);

        send("F5");
        do_reset();
        chk("rst_change_state", 64'(bus.state), 64'd0);
        send("F1234F");
        step(1'b0, 4'h0);
        chk("rst_pwd_restored", 64'(bus.state), 64'd3);
        send("E");
        send("F0000F");
        step(1'b0, 4'h0);
        send("0000F");
        step(1'b0, 4'h0);
        send("0000F");
        repeat (4) step(1'b0, 4'h0);
        chk("mid_lock", 64'(bus.lockout), 64'd1);
        do_reset();
        chk("rst_lockout", 64'(bus.lockout), 64'd0);

        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 5))
                0: begin
                    step(1'b1, 4'hF);
                    for (int i = 0; i < 4; i++) step(1'b1, mpwd[4*i +: 4]);
                    step(1'b1, 4'hF);
                end
                1: repeat (6) step(1'b1, 4'($urandom_range(0, 15)));
                2: repeat ($urandom_range(1, 25)) step(1'b0, 4'h0);
                3, 4: begin
                    step(1'b1, 4'hF);
                    repeat (4) step(1'b1, 4'($urandom_range(0, 13)));
                    step(1'b1, 4'hF);
                end
                default: if ($urandom_range(0, 9) == 0) do_reset();
                         else step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
